// File: rtl/weight_arbiter.sv
// Signed weight store for one neuron, shared round-robin between forward-pass reads
// and backward-pass saturating updates (w <= sat(w + delta)).
module weight_arbiter #(
  parameter  int W = 16,
  parameter  int N = 2,
  localparam int A = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_a_stb,
  input  logic [A-1:0]   s_a_dat,
  output logic           s_a_rdy,
  input  logic           m_d_rdy,
  output logic           m_d_stb,
  output logic [W-1:0]   m_d_dat,
  input  logic           s_u_stb,
  input  logic [A+W-1:0] s_u_dat,
  output logic           s_u_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    UPD  = 2'd2
  } state_t;

  localparam logic       PRIO_RD = 1'b0;
  localparam logic       PRIO_UP = 1'b1;
  localparam logic [A:0] N_LIM   = (A + 1)'(N);

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic [W-1:0]   rd_dat_q, rd_dat_d;
  logic [A-1:0]   upd_addr_q, upd_addr_d;
  logic [W:0]     sum_q, sum_d;
  logic [W-1:0]   weight_q [N];
  logic [W-1:0]   weight_d [N];

  logic           rd_grant, up_grant;
  logic [A-1:0]   u_addr;
  logic [W-1:0]   u_delta;
  logic           a_valid, u_valid, c_valid;
  logic [W-1:0]   rd_word, u_word;

  function automatic logic [W-1:0] sat(input logic [W:0] s);
    // The two top bits disagree only when the true sum left the W-bit range.
    if (s[W] != s[W-1]) begin
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return s[W-1:0];
  endfunction

  assign u_addr  = s_u_dat[A+W-1:W];
  assign u_delta = s_u_dat[W-1:0];
  assign a_valid = {1'b0, s_a_dat} < N_LIM;
  assign u_valid = {1'b0, u_addr} < N_LIM;
  assign c_valid = {1'b0, upd_addr_q} < N_LIM;
  assign rd_word = a_valid ? weight_q[s_a_dat] : '0;
  assign u_word  = u_valid ? weight_q[u_addr] : '0;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    rd_dat_d   = rd_dat_q;
    upd_addr_d = upd_addr_q;
    sum_d      = sum_q;
    rd_grant   = 1'b0;
    up_grant   = 1'b0;
    for (int i = 0; i < N; i++) begin
      weight_d[i] = weight_q[i];
    end

    case (state_q)
      IDLE: begin
        rd_grant = s_a_stb & (~s_u_stb | (prio_q == PRIO_RD));
        up_grant = s_u_stb & (~s_a_stb | (prio_q == PRIO_UP));
        if (rd_grant) begin
          rd_dat_d = rd_word;
          state_d  = READ;
          prio_d   = PRIO_UP;
        end else if (up_grant) begin
          upd_addr_d = u_addr;
          sum_d      = {u_word[W-1], u_word} + {u_delta[W-1], u_delta};
          state_d    = UPD;
          prio_d     = PRIO_RD;
        end
      end
      READ: begin
        if (m_d_rdy) begin
          state_d = IDLE;
        end
      end
      UPD: begin
        // Out-of-range addresses still complete the handshake but never write.
        for (int i = 0; i < N; i++) begin
          if (c_valid && (upd_addr_q == A'(i))) begin
            weight_d[i] = sat(sum_q);
          end
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= PRIO_RD;
      rd_dat_q   <= '0;
      upd_addr_q <= '0;
      sum_q      <= '0;
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rd_dat_q   <= rd_dat_d;
      upd_addr_q <= upd_addr_d;
      sum_q      <= sum_d;
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= weight_d[i];
      end
    end
  end

  // rdy is masked during reset so a master never sees a transfer that reset discards.
  assign s_a_rdy = rd_grant & ~rst;
  assign s_u_rdy = up_grant & ~rst;
  assign m_d_stb = (state_q == READ);
  assign m_d_dat = rd_dat_q;

endmodule

// File: tb/tb_weight_arbiter.sv
// Self-checking bench for weight_arbiter (N=3): scoreboard of expected read data,
// reference weight model with saturation, arbitration order and stall/reset checks.
module tb_weight_arbiter;

  localparam int W    = 16;
  localparam int N    = 3;
  localparam int A    = 2;
  localparam int MAXV = (2 ** (W - 1)) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic           clk;
  logic           rst;
  logic           s_a_stb;
  logic [A-1:0]   s_a_dat;
  logic           s_a_rdy;
  logic           m_d_rdy;
  logic           m_d_stb;
  logic [W-1:0]   m_d_dat;
  logic           s_u_stb;
  logic [A+W-1:0] s_u_dat;
  logic           s_u_rdy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_w [N];
  logic [W-1:0] exp_q [$];
  byte          grant_log [$];

  weight_arbiter #(.W(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_a_stb (s_a_stb),
    .s_a_dat (s_a_dat),
    .s_a_rdy (s_a_rdy),
    .m_d_rdy (m_d_rdy),
    .m_d_stb (m_d_stb),
    .m_d_dat (m_d_dat),
    .s_u_stb (s_u_stb),
    .s_u_dat (s_u_dat),
    .s_u_rdy (s_u_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_add(input logic [W-1:0] w, input logic [W-1:0] d);
    int s;
    s = int'($signed(w)) + int'($signed(d));
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return W'(s);
  endfunction

  // Handshakes are observed mid-cycle; inputs only change 2 time units after posedge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) model_w[i] = '0;
      exp_q.delete();
    end else begin
      if (s_a_stb && s_a_rdy) begin
        exp_q.push_back((int'(s_a_dat) < N) ? model_w[s_a_dat] : '0);
        grant_log.push_back("R");
        $display("[%0t] READ  accept addr=%0d", $time, s_a_dat);
      end
      if (s_u_stb && s_u_rdy) begin
        logic [A-1:0] ua;
        ua = s_u_dat[A+W-1:W];
        if (int'(ua) < N) model_w[ua] = model_add(model_w[ua], s_u_dat[W-1:0]);
        grant_log.push_back("U");
        $display("[%0t] UPD   accept addr=%0d delta=%h", $time, ua, s_u_dat[W-1:0]);
      end
      if (m_d_stb && m_d_rdy) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 32'(m_d_dat), 32'hDEAD_BEEF);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("rd_data", 32'(m_d_dat), 32'(e));
          $display("[%0t] DATA  got=%h exp=%h", $time, m_d_dat, e);
        end
      end
    end
  end

  // Called at a negedge with stb already driven; returns 2 units after the accepting edge.
  task automatic wait_a();
    int n = 0;
    while (!s_a_rdy) begin
      if (n == 50) begin
        check("a_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 s_a_stb = 1'b0;
  endtask

  task automatic wait_u();
    int n = 0;
    while (!s_u_rdy) begin
      if (n == 50) begin
        check("u_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 s_u_stb = 1'b0;
  endtask

  task automatic do_read(input logic [A-1:0] addr, input bit wait_done);
    int n = 0;
    @(posedge clk);
    #2;
    s_a_stb = 1'b1;
    s_a_dat = addr;
    @(negedge clk);
    wait_a();
    @(negedge clk);
    check("rd_latency", 32'(m_d_stb), 1);
    if (wait_done) begin
      while (m_d_stb) begin
        if (n == 50) begin
          check("d_timeout", 0, 1);
          break;
        end
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic do_upd(input logic [A-1:0] addr, input logic [W-1:0] delta);
    @(posedge clk);
    #2;
    s_u_stb = 1'b1;
    s_u_dat = {addr, delta};
    @(negedge clk);
    wait_u();
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_w;
    for (int i = 0; i < N; i++) model_w[i] = '0;
    rst     = 1'b1;
    s_a_stb = 1'b0;
    s_a_dat = '0;
    s_u_stb = 1'b0;
    s_u_dat = '0;
    m_d_rdy = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_stb", 32'(m_d_stb), 0);
    check("rst_dat", 32'(m_d_dat), 0);

    // Reset contents and first-read latency.
    for (int i = 0; i < N; i++) do_read(A'(i), 1'b1);

    // Positive then negative delta.
    do_upd(2'd1, 16'h0100);
    do_read(2'd1, 1'b1);
    do_upd(2'd1, 16'hFF00);
    do_read(2'd1, 1'b1);

    // Saturation at both rails.
    do_upd(2'd0, 16'h7F00);
    do_upd(2'd0, 16'h7F00);
    do_read(2'd0, 1'b1);
    for (int i = 0; i < 3; i++) do_upd(2'd0, 16'h8000);
    do_read(2'd0, 1'b1);
    do_upd(2'd2, 16'h1234);

    // Downstream stall with a competing update strobing.
    m_d_rdy = 1'b0;
    exp_w = model_w[2];
    do_read(2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) begin
        s_u_stb = 1'b1;
        s_u_dat = {2'd1, 16'h0003};
      end
      @(negedge clk);
      check("stall_stb", 32'(m_d_stb), 1);
      check("stall_dat", 32'(m_d_dat), 32'(exp_w));
      check("stall_ardy", 32'(s_a_rdy), 0);
      check("stall_urdy", 32'(s_u_rdy), 0);
    end
    @(posedge clk);
    #2 m_d_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("stall_fall", 32'(m_d_stb), 0);
    wait_u();
    do_read(2'd1, 1'b1);

    // Out-of-range address: read returns 0, update leaves everything alone.
    do_read(2'd3, 1'b1);
    do_upd(2'd3, 16'h0010);
    for (int i = 0; i < N; i++) do_read(A'(i), 1'b1);

    // Reset while data is pending downstream.
    m_d_rdy = 1'b0;
    do_read(2'd2, 1'b0);
    pulse_rst();
    @(negedge clk);
    check("rstread_stb", 32'(m_d_stb), 0);
    check("rstread_dat", 32'(m_d_dat), 0);
    m_d_rdy = 1'b1;
    for (int i = 0; i < N; i++) do_read(A'(i), 1'b1);

    // Continuous contention after reset: grants must alternate starting with a read.
    pulse_rst();
    grant_log.delete();
    @(posedge clk);
    #2;
    s_a_stb = 1'b1;
    s_a_dat = 2'd1;
    s_u_stb = 1'b1;
    s_u_dat = {2'd1, 16'h0005};
    repeat (8) @(posedge clk);
    #2;
    s_a_stb = 1'b0;
    s_u_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("arb_count", 32'(grant_log.size()), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check("arb_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'("R") : 32'("U"));
    end
    do_read(2'd1, 1'b1);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
